fp_result_obuf: RTL
===================

FP_RESULT_OBUF -- requirements
Module: fp_result_obuf

Interface
REQ-001 Parameter DEPTH, default 4, number of result entries held; SHALL be a power of two, 2..16.
REQ-002 Parameter FLAG_W, default 4, width of exception flags per result.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  multiplier result present this cycle.
REQ-006 in_ready  output  1  buffer can accept a result; high when not full.
REQ-007 in_result  input  32  IEEE-754 single-precision product.
REQ-008 in_flags  input  FLAG_W  {invalid, overflow, underflow, inexact}, MSB first.
REQ-009 out_valid  output  1  head entry available.
REQ-010 out_ready  input  1  consumer accepts head entry.
REQ-011 out_result  output  32  head entry result.
REQ-012 out_flags  output  FLAG_W  head entry flags.
REQ-013 sticky_flags  output  FLAG_W  OR of all flags accepted since reset or last clear.
REQ-014 flags_clr  input  1  single-cycle pulse clearing sticky_flags.
REQ-015 count  output  $clog2(DEPTH)+1  entries currently held.
REQ-016 drop_err  output  1  sticky; set when in_valid is high while in_ready is low.

Function
REQ-017 Write handshake: entry SHALL be stored when in_valid && in_ready at a rising edge.
REQ-018 Read handshake: head SHALL be removed when out_valid && out_ready at a rising edge.
REQ-019 out_result/out_flags SHALL come directly from registered storage (no combinational path from in_* to out_*).
REQ-020 Latency: an entry written into an empty buffer SHALL appear on out_valid the following cycle.
REQ-021 out_result/out_flags SHALL hold stable while out_valid && !out_ready.
REQ-022 Order SHALL be strictly FIFO.
REQ-023 Simultaneous write and read when non-empty: count SHALL be unchanged, both pointers advance.
REQ-024 Simultaneous write and read when full: read SHALL complete; write SHALL be refused (in_ready low that cycle; in_ready not dependent on out_ready).
REQ-025 Write when empty with simultaneous out_ready: SHALL be stored; no bypass.
REQ-026 Read and write pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-027 in_ready SHALL equal (count != DEPTH); out_valid SHALL equal (count != 0).
REQ-028 sticky_flags SHALL OR in in_flags on each accepted write.
REQ-029 flags_clr coincident with an accepted write: sticky_flags SHALL become that write's in_flags only.
REQ-030 drop_err SHALL remain set until reset; the refused result SHALL be discarded.
REQ-031 out_result SHALL read 32'h0000_0000 whenever out_valid is low.

Reset
REQ-032 On rst_n low, asynchronously: count=0, pointers=0, out_valid=0, in_ready=1 after release, sticky_flags=0, drop_err=0, out_result=0, out_flags=0.
REQ-033 Reset mid-transfer SHALL discard all held entries; storage contents need not be cleared.
REQ-034 First handshake SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-035 Shared package fp_pkg SHALL hold FP_W=32, FLAG_W default, and flag bit index constants (FLG_INV, FLG_OVF, FLG_UNF, FLG_INX).
REQ-036 One sub-module fp_obuf_ram (DEPTH x (32+FLAG_W) register array, one write port, one async read port) is natural; control/pointers SHALL stay in the top.

Verification
REQ-037 Reset then write 32'h3F80_0000 flags 4'b0001, out_ready=1 -> out_valid next cycle, out_result=32'h3F80_0000, count returns to 0.
REQ-038 out_ready=0, write 5 results (DEPTH=4) -> in_ready low after 4th, drop_err=1, drain yields first 4 in order.
REQ-039 Full buffer, in_valid=1 and out_ready=1 same cycle -> head removed, new entry refused, count=3.
REQ-040 Write flags 4'b0100 then 4'b0010 -> sticky_flags=4'b0110; flags_clr with write 4'b1000 -> sticky_flags=4'b1000.
REQ-041 Stream 20 results with random out_ready stalls -> output order matches input, out_result stable during stalls, pointers wrap correctly.
REQ-042 Assert rst_n low with 3 entries held -> out_valid=0, count=0 immediately, drop_err=0.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared floating-point result definitions: word width, flag width and flag bit positions.
package fp_pkg;
    localparam int FP_W       = 32;
    localparam int FLAG_W_DEF = 4;

    // Flag vector is {invalid, overflow, underflow, inexact}, MSB first.
    localparam int FLG_INV = 3;
    localparam int FLG_OVF = 2;
    localparam int FLG_UNF = 1;
    localparam int FLG_INX = 0;

    typedef logic [FP_W-1:0] fp_word_t;
endpackage

// File: rtl/fp_obuf_ram.sv
// Result storage array: one synchronous write port, one asynchronous read port.
// Latency: write visible on read port the cycle after the write edge; no backpressure.
module fp_obuf_ram #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/fp_result_obuf.sv
// FIFO buffer for multiplier results with sticky exception flags and overflow error.
// Latency: one cycle from accepted write to out_valid; in_ready = not full, independent of out_ready.
module fp_result_obuf
    import fp_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int FLAG_W = FLAG_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [FP_W-1:0]          in_result,
    input  logic [FLAG_W-1:0]        in_flags,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [FP_W-1:0]          out_result,
    output logic [FLAG_W-1:0]        out_flags,
    output logic [FLAG_W-1:0]        sticky_flags,
    input  logic                     flags_clr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = FP_W + FLAG_W;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          wr_en;
    logic          rd_en;
    logic [EW-1:0] rd_data;

    assign in_ready  = (cnt != CW'(DEPTH));
    assign out_valid = (cnt != '0);
    assign count     = cnt;
    assign wr_en     = in_valid && in_ready;
    assign rd_en     = out_valid && out_ready;

    fp_obuf_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata ({in_result, in_flags}),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // Stale storage is masked so an empty buffer always presents zeros.
    assign out_result = out_valid ? rd_data[EW-1:FLAG_W] : '0;
    assign out_flags  = out_valid ? rd_data[FLAG_W-1:0]  : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            // DEPTH is a power of two, so pointer increments wrap naturally.
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_flags <= '0;
            drop_err     <= 1'b0;
        end else begin
            if (flags_clr) begin
                sticky_flags <= wr_en ? in_flags : '0;
            end else if (wr_en) begin
                sticky_flags <= sticky_flags | in_flags;
            end
            if (in_valid && !in_ready) begin
                drop_err <= 1'b1;
            end
        end
    end
endmodule
